// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit engine: shift register, baud divider and frame FSM (optional break via UART_TX_BREAK_EN)

module uart_tx_frame #(
    parameter int WORD_LENGTH = 8,
    parameter int BAUD_DIV    = 5208
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_LENGTH-1:0] DataTX,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic                   parity_en,
    input  logic                   parity_odd,
    input  logic                   two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic                   tx_break,
`endif
    output logic                   SerialDataOut,
    output logic                   tx_busy,
    output logic                   tx_done
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int CW = $clog2(WORD_LENGTH + 1);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WORD_LENGTH - 1);

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK, RECOVER} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

    state_t                 state;
    logic [WORD_LENGTH-1:0] shift_reg;
    logic [BW-1:0]          baud_cnt;
    logic [CW-1:0]          bit_cnt;
    logic                   par_en_q;
    logic                   par_bit_q;
    logic                   two_stop_q;

    // Idle is exactly "ready"; break recovery also holds ready low
    assign tx_busy = ~tx_ready;

    // Frame FSM with registered line, handshake and completion outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            SerialDataOut <= 1'b1;
            tx_ready      <= 1'b1;
            tx_done       <= 1'b0;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            par_en_q      <= 1'b0;
            par_bit_q     <= 1'b0;
            two_stop_q    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    SerialDataOut <= 1'b1;
`ifdef UART_TX_BREAK_EN
                    if (tx_break) begin
                        state         <= BRK;
                        SerialDataOut <= 1'b0;
                        tx_ready      <= 1'b0;
                    end else
`endif
                    if (tx_valid && tx_ready) begin
                        // Latch the whole frame description; the parity bit is
                        // resolved now so later input changes cannot leak in
                        state         <= START;
                        SerialDataOut <= 1'b0;
                        tx_ready      <= 1'b0;
                        baud_cnt      <= BAUD_LOAD;
                        bit_cnt       <= '0;
                        shift_reg     <= DataTX;
                        par_en_q      <= parity_en;
                        par_bit_q     <= (^DataTX) ^ parity_odd;
                        two_stop_q    <= two_stop;
                    end
                end
                START: begin
                    if (baud_cnt == '0) begin
                        state         <= DATA;
                        SerialDataOut <= shift_reg[0];
                        baud_cnt      <= BAUD_LOAD;
                        bit_cnt       <= '0;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == '0) begin
                        shift_reg <= shift_reg >> 1;
                        baud_cnt  <= BAUD_LOAD;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (par_en_q) begin
                                state         <= PARITY;
                                SerialDataOut <= par_bit_q;
                            end else begin
                                state         <= STOP;
                                SerialDataOut <= 1'b1;
                            end
                        end else begin
                            bit_cnt       <= bit_cnt + CW'(1);
                            SerialDataOut <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                PARITY: begin
                    if (baud_cnt == '0) begin
                        state         <= STOP;
                        SerialDataOut <= 1'b1;
                        baud_cnt      <= BAUD_LOAD;
                        bit_cnt       <= '0;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                STOP: begin
                    SerialDataOut <= 1'b1;
                    if (baud_cnt == '0) begin
                        if (two_stop_q && bit_cnt == '0) begin
                            bit_cnt  <= CW'(1);
                            baud_cnt <= BAUD_LOAD;
                        end else begin
                            state    <= IDLE;
                            tx_ready <= 1'b1;
                            tx_done  <= 1'b1;
                            bit_cnt  <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
`ifdef UART_TX_BREAK_EN
                BRK: begin
                    SerialDataOut <= 1'b0;
                    if (!tx_break) begin
                        state         <= RECOVER;
                        SerialDataOut <= 1'b1;
                        baud_cnt      <= BAUD_LOAD;
                        bit_cnt       <= '0;
                    end
                end
                RECOVER: begin
                    // Two bit-times of mark so the receiver resynchronises
                    SerialDataOut <= 1'b1;
                    if (baud_cnt == '0) begin
                        if (bit_cnt == '0) begin
                            bit_cnt  <= CW'(1);
                            baud_cnt <= BAUD_LOAD;
                        end else begin
                            state    <= IDLE;
                            tx_ready <= 1'b1;
                            bit_cnt  <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
`endif
                default: begin
                    state         <= IDLE;
                    SerialDataOut <= 1'b1;
                    tx_ready      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - randomized self-checking bench for uart_tx_frame

module tb_uart_tx_frame;

    localparam int WL = 8;
    localparam int BD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [WL-1:0] DataTX;
    logic          tx_valid;
    logic          tx_ready;
    logic          parity_en;
    logic          parity_odd;
    logic          two_stop;
    logic          SerialDataOut;
    logic          tx_busy;
    logic          tx_done;
`ifdef UART_TX_BREAK_EN
    logic          tx_break = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_frame #(.WORD_LENGTH(WL), .BAUD_DIV(BD)) dut (
        .clk           (clk),
        .reset         (reset),
        .DataTX        (DataTX),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .two_stop      (two_stop),
`ifdef UART_TX_BREAK_EN
        .tx_break      (tx_break),
`endif
        .SerialDataOut (SerialDataOut),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line level during bit slot idx of a frame: start, data LSB first, parity, stops
    function automatic logic frame_bit(input int idx, input logic [WL-1:0] w,
                                       input logic pe, input logic po);
        if (idx == 0) return 1'b0;
        if (idx <= WL) return w[idx-1];
        if (pe && idx == WL + 1) return logic'((($countones(w) + int'(po)) % 2) != 0);
        return 1'b1;
    endfunction

    function automatic int frame_cycles(input logic pe, input logic ts);
        return (1 + WL + int'(pe) + (ts ? 2 : 1)) * BD;
    endfunction

    task automatic idle_cycles(input int n);
        tx_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("idle_line", SerialDataOut, 1);
            check("idle_ready", tx_ready, 1);
            check("idle_done", tx_done, 0);
        end
    endtask

    // Call at a negedge; returns at the negedge of the tx_done cycle
    task automatic send_frame(input logic [WL-1:0] w, input logic pe, input logic po, input logic ts);
        int ncyc;
        ncyc = frame_cycles(pe, ts);
        check("ready_before", tx_ready, 1);
        DataTX = w; parity_en = pe; parity_odd = po; two_stop = ts; tx_valid = 1'b1;
        @(posedge clk);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            check("line", SerialDataOut, frame_bit(c / BD, w, pe, po));
            check("busy", tx_busy, 1);
            check("done_early", tx_done, 0);
            DataTX     = WL'($urandom);
            parity_en  = 1'($urandom);
            parity_odd = 1'($urandom);
            two_stop   = 1'($urandom);
            tx_valid   = (c == ncyc - 1) ? 1'b0 : 1'($urandom);
        end
        @(negedge clk);
        check("done", tx_done, 1);
        check("ready_at_done", tx_ready, 1);
        check("busy_at_done", tx_busy, 0);
        check("line_at_done", SerialDataOut, 1);
    endtask

    task automatic reset_mid_frame(input logic [WL-1:0] w);
        DataTX = w; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0; tx_valid = 1'b1;
        @(posedge clk);
        // Slot 4 is data bit 3; assert reset in its second cycle
        for (int c = 0; c < 4 * BD + 2; c++) begin
            @(negedge clk);
            check("rst_line", SerialDataOut, frame_bit(c / BD, w, 1'b0, 1'b0));
            tx_valid = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_line", SerialDataOut, 1);
        check("rst_mid_ready", tx_ready, 1);
        check("rst_mid_busy", tx_busy, 0);
        check("rst_mid_done", tx_done, 0);
        reset = 1'b0;
        idle_cycles(3 * BD * 12);
    endtask

    initial begin
        reset = 1'b1; tx_valid = 1'b0; DataTX = '0;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_line", SerialDataOut, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        reset = 1'b0;
        idle_cycles(3);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0); idle_cycles(2);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0); idle_cycles(1);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0); idle_cycles(1);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1); idle_cycles(1);

        // Back-to-back: the tx_done cycle is the single idle gap
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        idle_cycles(2);

        repeat (30) begin
            int gap;
            send_frame(WL'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            gap = $urandom_range(0, 2);
            if (gap != 0) idle_cycles(gap);
        end
        idle_cycles(1);

        reset_mid_frame(8'h3C);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
